alu_arbiter: RTL and testbench

Shares the single combinational `alu` between two requesters, such as the core's execute stage and a debug/DMA port. Each request is one ALU operation. A 16-bit multiply is sequenced as two ALU passes: low segment, then high segment. Requesters see a valid/ready request channel and one shared response channel. The block sits between the requesters and the `alu` instance and drives all of the ALU's select and operand ports.

---
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters. Each accepted request
// becomes one ALU pass, or two passes for a wide multiply (low product byte
// first, then high byte). The result is returned on one shared response
// channel that holds until the consumer takes it.
//
// Ports:
//   clk_in, rst_in              clock, asynchronous active-high reset
//   req{0,1}_valid_in/ready_out request handshake per port
//   req{0,1}_unit_sel_in        ALU unit select
//   req{0,1}_op_sel_in          sub / mul type / right-shift select
//   req{0,1}_wide_in            full 16-bit product (multiply only)
//   req{0,1}_acc_in/src_in      8-bit operands
//   alu_*_out                   registered ALU selects and operands
//   alu_res_in                  combinational ALU result
//   rsp_valid_out/ready_in      response handshake
//   rsp_id_out, rsp_data_out    issuing port and 16-bit result
//   busy_out                    high whenever an operation is in flight
module alu_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req0_valid_in,
  output logic        req0_ready_out,
  input  logic [2:0]  req0_unit_sel_in,
  input  logic        req0_op_sel_in,
  input  logic        req0_wide_in,
  input  logic [7:0]  req0_acc_in,
  input  logic [7:0]  req0_src_in,
  input  logic        req1_valid_in,
  output logic        req1_ready_out,
  input  logic [2:0]  req1_unit_sel_in,
  input  logic        req1_op_sel_in,
  input  logic        req1_wide_in,
  input  logic [7:0]  req1_acc_in,
  input  logic [7:0]  req1_src_in,
  output logic [2:0]  alu_unit_sel_out,
  output logic        alu_op_sel_out,
  output logic        alu_mul_seg_sel_out,
  output logic [7:0]  alu_acc_out,
  output logic [7:0]  alu_src_out,
  input  logic [7:0]  alu_res_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic        rsp_id_out,
  output logic [15:0] rsp_data_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    EXEC_HI = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [2:0] UNIT_MUL = 3'b001;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [2:0]  unitSel_q, unitSel_d;
  logic        opSel_q, opSel_d;
  logic        wideEff_q, wideEff_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  src_q, src_d;
  logic        id_q, id_d;
  logic [15:0] rspData_q, rspData_d;
  logic        grant0, grant1;

  // Round-robin grant, only in IDLE. The favoured port wins a tie; a lone
  // requester always wins. Grants are masked while reset is held so that
  // every output reads zero during reset.
  assign grant0 = !rst_in && (state_q == IDLE) && req0_valid_in
                  && (!prio_q || !req1_valid_in);
  assign grant1 = !rst_in && (state_q == IDLE) && req1_valid_in
                  && (prio_q || !req0_valid_in);

  assign req0_ready_out      = grant0;
  assign req1_ready_out      = grant1;
  assign alu_unit_sel_out    = unitSel_q;
  assign alu_op_sel_out      = opSel_q;
  assign alu_acc_out         = acc_q;
  assign alu_src_out         = src_q;
  assign alu_mul_seg_sel_out = (state_q == EXEC_HI);
  assign rsp_valid_out       = (state_q == RESP);
  assign rsp_id_out          = id_q;
  assign rsp_data_out        = rspData_q;
  assign busy_out            = (state_q != IDLE);

  // State, priority, operand and response registers. The ALU is fed only
  // from these registers so its inputs stay constant for a whole pass even
  // if a requester changes its payload after being accepted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      unitSel_q <= 3'b000;
      opSel_q   <= 1'b0;
      wideEff_q <= 1'b0;
      acc_q     <= 8'h00;
      src_q     <= 8'h00;
      id_q      <= 1'b0;
      rspData_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      unitSel_q <= unitSel_d;
      opSel_q   <= opSel_d;
      wideEff_q <= wideEff_d;
      acc_q     <= acc_d;
      src_q     <= src_d;
      id_q      <= id_d;
      rspData_q <= rspData_d;
    end
  end

  // Next-state logic. An accept latches the winning port's payload and
  // hands priority to the other port. EXEC writes the low result byte and
  // either clears the high byte (narrow) or moves on to the high-product
  // pass. RESP holds everything until the consumer takes the response.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    unitSel_d = unitSel_q;
    opSel_d   = opSel_q;
    wideEff_d = wideEff_q;
    acc_d     = acc_q;
    src_d     = src_q;
    id_d      = id_q;
    rspData_d = rspData_q;

    case (state_q)
      IDLE: begin
        if (grant1) begin
          state_d   = EXEC;
          prio_d    = 1'b0;
          id_d      = 1'b1;
          unitSel_d = req1_unit_sel_in;
          opSel_d   = req1_op_sel_in;
          wideEff_d = req1_wide_in && (req1_unit_sel_in == UNIT_MUL);
          acc_d     = req1_acc_in;
          src_d     = req1_src_in;
        end else if (grant0) begin
          state_d   = EXEC;
          prio_d    = 1'b1;
          id_d      = 1'b0;
          unitSel_d = req0_unit_sel_in;
          opSel_d   = req0_op_sel_in;
          wideEff_d = req0_wide_in && (req0_unit_sel_in == UNIT_MUL);
          acc_d     = req0_acc_in;
          src_d     = req0_src_in;
        end
      end
      EXEC: begin
        rspData_d[7:0] = alu_res_in;
        if (wideEff_q) begin
          state_d = EXEC_HI;
        end else begin
          rspData_d[15:8] = 8'h00;
          state_d         = RESP;
        end
      end
      EXEC_HI: begin
        rspData_d[15:8] = alu_res_in;
        state_d         = RESP;
      end
      RESP: begin
        if (rsp_ready_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Drives alu_arbiter with directed and random requests, supplies a
// behavioural ALU on alu_res_in, and checks every cycle against a
// cycle-level model of the arbiter built from its stated rules.
module tb_alu_arbiter;

  typedef struct packed {
    logic [2:0] unit;
    logic       op;
    logic       wide;
    logic [7:0] acc;
    logic [7:0] src;
  } req_t;

  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_RESP = 2;

  logic        clk_in;
  logic        rst_in;
  logic        valid [2];
  req_t        pay [2];
  logic        req0_ready_out, req1_ready_out;
  logic [2:0]  alu_unit_sel_out;
  logic        alu_op_sel_out, alu_mul_seg_sel_out;
  logic [7:0]  alu_acc_out, alu_src_out, aluRes;
  logic        rsp_valid_out, rsp_ready_in, rsp_id_out, busy_out;
  logic [15:0] rsp_data_out;

  int          testCount = 0;
  int          failCount = 0;
  bit          drop [2];
  bit          stage [2];
  req_t        stagePay [2];
  bit          forceXor = 1'b0;
  int          mState = M_IDLE;
  int          mCount = 0;
  bit          mPrio = 1'b0;
  req_t        mCur;
  bit          mCurId = 1'b0;
  logic [15:0] lastRspData = 16'h0000;
  logic        lastRspId = 1'b0;
  int          rspCount = 0;
  int          grantLog [$];
  int          snapCount;

  alu_arbiter dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .req0_valid_in       (valid[0]),
    .req0_ready_out      (req0_ready_out),
    .req0_unit_sel_in    (pay[0].unit),
    .req0_op_sel_in      (pay[0].op),
    .req0_wide_in        (pay[0].wide),
    .req0_acc_in         (pay[0].acc),
    .req0_src_in         (pay[0].src),
    .req1_valid_in       (valid[1]),
    .req1_ready_out      (req1_ready_out),
    .req1_unit_sel_in    (pay[1].unit),
    .req1_op_sel_in      (pay[1].op),
    .req1_wide_in        (pay[1].wide),
    .req1_acc_in         (pay[1].acc),
    .req1_src_in         (pay[1].src),
    .alu_unit_sel_out    (alu_unit_sel_out),
    .alu_op_sel_out      (alu_op_sel_out),
    .alu_mul_seg_sel_out (alu_mul_seg_sel_out),
    .alu_acc_out         (alu_acc_out),
    .alu_src_out         (alu_src_out),
    .alu_res_in          (aluRes),
    .rsp_valid_out       (rsp_valid_out),
    .rsp_ready_in        (rsp_ready_in),
    .rsp_id_out          (rsp_id_out),
    .rsp_data_out        (rsp_data_out),
    .busy_out            (busy_out)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Behavioural stand-in for the shared ALU, one 8-bit slice per pass.
  function automatic logic [7:0] aluFn(input logic [2:0] unit, input logic op,
                                       input logic seg, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] prod;
    if (op) prod = {{8{a[7]}}, a} * {{8{b[7]}}, b};
    else    prod = {8'h00, a} * {8'h00, b};
    case (unit)
      3'b000:  return op ? a - b : a + b;
      3'b001:  return seg ? prod[15:8] : prod[7:0];
      3'b010:  return op ? a >> b[2:0] : a << b[2:0];
      3'b011:  return b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      3'b110:  return a & b;
      default: return a;
    endcase
  endfunction

  assign aluRes = aluFn(alu_unit_sel_out, alu_op_sel_out, alu_mul_seg_sel_out,
                        alu_acc_out, alu_src_out);

  // Expected response word, from integer arithmetic on the whole request.
  function automatic logic [15:0] refResult(input req_t r);
    int a, s, sa, ss, v;
    a  = int'(r.acc);
    s  = int'(r.src);
    sa = r.acc[7] ? a - 256 : a;
    ss = r.src[7] ? s - 256 : s;
    case (r.unit)
      3'b000:  v = r.op ? (a - s + 256) % 256 : (a + s) % 256;
      3'b001:  begin
        v = r.op ? (sa * ss) & 65535 : a * s;
        if (!r.wide) v = v & 255;
      end
      3'b010:  v = r.op ? a >> r.src[2:0] : (a << r.src[2:0]) & 255;
      3'b011:  v = s;
      3'b100:  v = a | s;
      3'b101:  v = a ^ s;
      3'b110:  v = a & s;
      default: v = a;
    endcase
    return v[15:0];
  endfunction

  // Random request payload; contention runs force the XOR unit.
  function automatic req_t newPayload();
    req_t r;
    r.unit = forceXor ? 3'b101 : 3'($urandom_range(7));
    r.op   = 1'($urandom_range(1));
    r.wide = 1'($urandom_range(1));
    r.acc  = 8'($urandom_range(255));
    r.src  = 8'($urandom_range(255));
    return r;
  endfunction

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue a request on a port; it is raised at the next falling edge.
  task automatic applyStimulus(input int port, input logic [2:0] unit,
                               input logic op, input logic wide,
                               input logic [7:0] acc, input logic [7:0] src);
    stage[port]         = 1'b1;
    stagePay[port].unit = unit;
    stagePay[port].op   = op;
    stagePay[port].wide = wide;
    stagePay[port].acc  = acc;
    stagePay[port].src  = src;
  endtask

  task automatic resetModel();
    mState = M_IDLE;
    mCount = 0;
    mPrio  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drop[p]  = 1'b0;
      stage[p] = 1'b0;
    end
  endtask

  // Asynchronous reset mid-cycle: every output must drop to zero at once,
  // even with both requesters asking. Released on the next falling edge.
  task automatic resetDut();
    #2;
    rst_in   = 1'b1;
    valid[0] = 1'b1;
    valid[1] = 1'b1;
    #1;
    checkOutput("rst_ready0", 16'(req0_ready_out), 16'h0);
    checkOutput("rst_ready1", 16'(req1_ready_out), 16'h0);
    checkOutput("rst_unit", 16'(alu_unit_sel_out), 16'h0);
    checkOutput("rst_op", 16'(alu_op_sel_out), 16'h0);
    checkOutput("rst_seg", 16'(alu_mul_seg_sel_out), 16'h0);
    checkOutput("rst_acc", 16'(alu_acc_out), 16'h0);
    checkOutput("rst_src", 16'(alu_src_out), 16'h0);
    checkOutput("rst_rsp_valid", 16'(rsp_valid_out), 16'h0);
    checkOutput("rst_rsp_id", 16'(rsp_id_out), 16'h0);
    checkOutput("rst_rsp_data", rsp_data_out, 16'h0);
    checkOutput("rst_busy", 16'(busy_out), 16'h0);
    @(negedge clk_in);
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    rst_in   = 1'b0;
    resetModel();
  endtask

  // One clock of the cycle model. At the falling edge inputs are updated,
  // then every output is compared against what the model expects, and the
  // model advances to where the next rising edge will leave the block.
  task automatic stepCycle(input int raisePct, input int readyPct);
    int   g;
    logic wideEff;
    logic expSeg;
    @(negedge clk_in);
    for (int p = 0; p < 2; p++) begin
      if (drop[p]) begin
        valid[p] = 1'b0;
        drop[p]  = 1'b0;
      end
      if (stage[p]) begin
        valid[p] = 1'b1;
        pay[p]   = stagePay[p];
        stage[p] = 1'b0;
      end else if (!valid[p] && raisePct > 0
                   && int'($urandom_range(99)) < raisePct) begin
        valid[p] = 1'b1;
        pay[p]   = newPayload();
      end
    end
    rsp_ready_in = (int'($urandom_range(99)) < readyPct);
    #1;
    wideEff = mCur.wide && (mCur.unit == 3'b001);
    expSeg  = (mState == M_EXEC) && wideEff && (mCount == 1);
    checkOutput("busy", 16'(busy_out), 16'(mState != M_IDLE));
    checkOutput("rsp_valid", 16'(rsp_valid_out), 16'(mState == M_RESP));
    checkOutput("seg_sel", 16'(alu_mul_seg_sel_out), 16'(expSeg));
    if (mState != M_IDLE) begin
      checkOutput("alu_unit", 16'(alu_unit_sel_out), 16'(mCur.unit));
      checkOutput("alu_op", 16'(alu_op_sel_out), 16'(mCur.op));
      checkOutput("alu_acc", 16'(alu_acc_out), 16'(mCur.acc));
      checkOutput("alu_src", 16'(alu_src_out), 16'(mCur.src));
    end
    if (mState == M_RESP) begin
      checkOutput("rsp_id", 16'(rsp_id_out), 16'(mCurId));
      checkOutput("rsp_data", rsp_data_out, refResult(mCur));
    end
    g = -1;
    if (mState == M_IDLE) begin
      if (valid[0] && valid[1]) g = int'(mPrio);
      else if (valid[0])        g = 0;
      else if (valid[1])        g = 1;
    end
    checkOutput("req0_ready", 16'(req0_ready_out), 16'(g == 0));
    checkOutput("req1_ready", 16'(req1_ready_out), 16'(g == 1));
    case (mState)
      M_IDLE: begin
        if (g >= 0) begin
          mCur    = pay[g];
          mCurId  = g[0];
          drop[g] = 1'b1;
          mPrio   = ~g[0];
          mState  = M_EXEC;
          mCount  = (pay[g].wide && pay[g].unit == 3'b001) ? 2 : 1;
          grantLog.push_back(g);
        end
      end
      M_EXEC: begin
        mCount--;
        if (mCount == 0) mState = M_RESP;
      end
      default: begin
        if (rsp_ready_in) begin
          lastRspData = rsp_data_out;
          lastRspId   = rsp_id_out;
          rspCount++;
          mState      = M_IDLE;
        end
      end
    endcase
  endtask

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Main directed and random sequence.
  initial begin
    bit drained;
    rst_in       = 1'b1;
    rsp_ready_in = 1'b1;
    for (int p = 0; p < 2; p++) begin
      valid[p] = 1'b0;
      pay[p]   = '0;
      drop[p]  = 1'b0;
      stage[p] = 1'b0;
    end
    mCur = '0;
    resetDut();

    // Narrow add on port 0.
    applyStimulus(0, 3'b000, 1'b0, 1'b0, 8'h05, 8'h03);
    repeat (3) stepCycle(0, 100);
    checkOutput("add_count", 16'(rspCount), 16'd1);
    checkOutput("add_data", lastRspData, 16'h0008);
    checkOutput("add_id", 16'(lastRspId), 16'h0);

    // Subtract wraps modulo 256, port 1.
    applyStimulus(1, 3'b000, 1'b1, 1'b0, 8'h03, 8'h05);
    repeat (3) stepCycle(0, 100);
    checkOutput("sub_data", lastRspData, 16'h00FE);
    checkOutput("sub_id", 16'(lastRspId), 16'h1);

    // Wide multiply takes one extra cycle; narrow multiply keeps low byte.
    applyStimulus(0, 3'b001, 1'b0, 1'b1, 8'h10, 8'h20);
    repeat (4) stepCycle(0, 100);
    checkOutput("wmul_data", lastRspData, 16'h0200);
    applyStimulus(1, 3'b001, 1'b0, 1'b0, 8'h10, 8'h20);
    repeat (3) stepCycle(0, 100);
    checkOutput("nmul_data", lastRspData, 16'h0000);

    // Wide flag is ignored outside the multiply unit.
    applyStimulus(0, 3'b010, 1'b0, 1'b1, 8'h81, 8'h01);
    repeat (3) stepCycle(0, 100);
    checkOutput("shift_data", lastRspData, 16'h0002);
    checkOutput("shift_count", 16'(rspCount), 16'd5);

    // Backpressure: response held for 5 cycles while port 0 waits.
    applyStimulus(1, 3'b100, 1'b0, 1'b0, 8'hA0, 8'h0C);
    repeat (2) stepCycle(0, 100);
    applyStimulus(0, 3'b110, 1'b0, 1'b0, 8'hF0, 8'h3C);
    repeat (5) stepCycle(0, 0);
    checkOutput("bp_held_count", 16'(rspCount), 16'd5);
    stepCycle(0, 100);
    checkOutput("bp_data", lastRspData, 16'h00AC);
    checkOutput("bp_id", 16'(lastRspId), 16'h1);
    repeat (3) stepCycle(0, 100);
    checkOutput("bp_next_data", lastRspData, 16'h0030);
    checkOutput("bp_next_id", 16'(lastRspId), 16'h0);

    // Contention from reset: both ports always requesting XOR operations.
    resetDut();
    grantLog.delete();
    forceXor = 1'b1;
    applyStimulus(0, 3'b101, 1'b0, 1'b0, 8'h5A, 8'h0F);
    applyStimulus(1, 3'b101, 1'b0, 1'b0, 8'hC3, 8'hFF);
    repeat (13) stepCycle(100, 100);
    forceXor = 1'b0;
    checkOutput("cont_grants", 16'(grantLog.size() >= 4), 16'h1);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) begin
      checkOutput($sformatf("cont_grant%0d", i), 16'(grantLog[i]), 16'(i % 2));
    end

    // Random traffic with random response backpressure, then drain.
    repeat (300) stepCycle(40, 70);
    drained = 1'b0;
    for (int i = 0; i < 60 && !drained; i++) begin
      stepCycle(0, 100);
      drained = (mState == M_IDLE) && !valid[0] && !valid[1] && !drop[0] && !drop[1];
    end
    checkOutput("drain", 16'(drained), 16'h1);

    // Reset during the high-product pass drops the operation entirely.
    applyStimulus(1, 3'b001, 1'b1, 1'b1, 8'h7F, 8'h85);
    repeat (3) stepCycle(0, 100);
    snapCount = rspCount;
    resetDut();
    grantLog.delete();
    applyStimulus(0, 3'b101, 1'b0, 1'b0, 8'h11, 8'h22);
    applyStimulus(1, 3'b101, 1'b0, 1'b0, 8'h33, 8'h44);
    repeat (7) stepCycle(0, 100);
    checkOutput("post_rst_grants", 16'(grantLog.size()), 16'd2);
    if (grantLog.size() >= 2) begin
      checkOutput("post_rst_first", 16'(grantLog[0]), 16'd0);
      checkOutput("post_rst_second", 16'(grantLog[1]), 16'd1);
    end
    checkOutput("post_rst_rsps", 16'(rspCount - snapCount), 16'd2);
    checkOutput("post_rst_last", lastRspData, 16'h0077);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
